// File: rtl/slave_mem_port.sv
// Memory slave on a shared tristate bus with a fixed, configurable accept-to-ack latency.
// Define SLAVE_MEM_PORT_CNT_EN to add the saturating rd_cnt/wr_cnt completion counters.
module slave_mem_port #(
    parameter int M          = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int LATENCY    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sreq,
    input  logic          scmd,
    input  logic [M-1:0]  saddr,
    inout  wire  [M-1:0]  srw,
    output logic          sack
`ifdef SLAVE_MEM_PORT_CNT_EN
    ,
    output logic [15:0]   rd_cnt,
    output logic [15:0]   wr_cnt
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

    typedef struct packed {
        logic                  rd;
        logic [DEPTH_LOG2-1:0] idx;
        logic [M-1:0]          data;
    } req_t;

    state_t       state, state_nxt;
    logic [3:0]   cnt;
    req_t         req_q;
    logic [M-1:0] mem [DEPTH];
    logic         drive;
    logic         do_wr;

    // Upper address bits alias onto the decoded range.
    logic [M-DEPTH_LOG2-1:0] unused_addr_hi;
    assign unused_addr_hi = saddr[M-1:DEPTH_LOG2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sack      = 1'b0;
        drive     = 1'b0;
        do_wr     = 1'b0;
        case (state)
            IDLE: if (sreq) state_nxt = (LATENCY == 0) ? ACK : WAIT;
            WAIT: begin
                // A withdrawn request wins over a simultaneous terminal count.
                if (!sreq)            state_nxt = IDLE;
                else if (cnt == 4'd1) state_nxt = ACK;
            end
            ACK: begin
                sack      = 1'b1;
                drive     = req_q.rd;
                do_wr     = !req_q.rd;
                state_nxt = HOLD;
            end
            HOLD: if (!sreq) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= 4'd0;
            req_q <= '0;
        end else begin
            case (state)
                IDLE: if (sreq) begin
                    cnt   <= 4'(LATENCY);
                    req_q <= '{rd: scmd, idx: saddr[DEPTH_LOG2-1:0], data: srw};
                end
                WAIT: cnt <= sreq ? cnt - 4'd1 : 4'd0;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_wr) begin
            mem[req_q.idx] <= req_q.data;
        end
    end

    assign srw = drive ? mem[req_q.idx] : {M{1'bz}};

`ifdef SLAVE_MEM_PORT_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt <= 16'd0;
            wr_cnt <= 16'd0;
        end else if (state == ACK) begin
            if (req_q.rd) begin
                if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
            end else begin
                if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end
`else
    // Completions update only memory and the bus; nothing is counted.
`endif

endmodule
